// File: rtl/umi_rmw_endpoint.sv
// UMI device-side endpoint: accepts one request at a time, executes reads,
// writes and read-modify-write atomics against a single-port local memory and
// returns a response for every non-posted request.
//
// Optional feature macro: UMI_RMW_ERRRESP_EN
//   defined   -> unsupported requests with command[0]=1 get an error response
//   undefined -> every unsupported request is silently consumed
//
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   udev_req_*           request channel (valid/ready, cmd, dstaddr, srcaddr, data)
//   udev_resp_*          response channel (valid/ready, cmd, dstaddr, data)
//   loc_read/loc_write   local memory strobes (never both high)
//   loc_addr/loc_wrdata  local memory address / write data
//   loc_rddata           local memory read data, valid the cycle after loc_read
module umi_rmw_endpoint #(
    parameter int unsigned CW = 32,
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          udev_req_valid,
    input  logic [CW-1:0] udev_req_cmd,
    input  logic [AW-1:0] udev_req_dstaddr,
    input  logic [AW-1:0] udev_req_srcaddr,
    input  logic [DW-1:0] udev_req_data,
    output logic          udev_req_ready,
    output logic          udev_resp_valid,
    output logic [CW-1:0] udev_resp_cmd,
    output logic [AW-1:0] udev_resp_dstaddr,
    output logic [DW-1:0] udev_resp_data,
    input  logic          udev_resp_ready,
    output logic          loc_read,
    output logic          loc_write,
    output logic [AW-1:0] loc_addr,
    output logic [DW-1:0] loc_wrdata,
    input  logic [DW-1:0] loc_rddata
);

    localparam logic [3:0] OP_READ       = 4'h1;
    localparam logic [3:0] OP_WRITE      = 4'h3;
    localparam logic [3:0] OP_POSTED     = 4'h5;
    localparam logic [3:0] OP_ATOMIC     = 4'h9;
    localparam logic [3:0] OP_RESP_READ  = 4'h2;
    localparam logic [3:0] OP_RESP_WRITE = 4'h4;

    localparam logic [7:0] AMO_ADD  = 8'h00;
    localparam logic [7:0] AMO_AND  = 8'h01;
    localparam logic [7:0] AMO_OR   = 8'h02;
    localparam logic [7:0] AMO_XOR  = 8'h03;
    localparam logic [7:0] AMO_MAX  = 8'h04;
    localparam logic [7:0] AMO_MIN  = 8'h05;
    localparam logic [7:0] AMO_MAXU = 8'h06;
    localparam logic [7:0] AMO_MINU = 8'h07;
    localparam logic [7:0] AMO_SWAP = 8'h08;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_RMW  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [CW-1:0] cmd_q;
    logic [AW-1:0] dst_q;
    logic [AW-1:0] src_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] old_q;       // value returned in the response
    logic          rd_fresh_q;  // first RESP cycle of a READ: data still on loc_rddata
    logic          err_q;

    logic          req_read;
    logic          req_write;
    logic          req_posted;
    logic          req_atomic;
    logic          req_err;
    logic          accept;

    logic          cap_read;
    logic          cap_posted;

    logic [DW-1:0] rmw_result;
    logic [CW-1:0] resp_cmd_c;

    // Classification of the incoming request
    assign req_read   = (udev_req_cmd[3:0] == OP_READ);
    assign req_write  = (udev_req_cmd[3:0] == OP_WRITE);
    assign req_posted = (udev_req_cmd[3:0] == OP_POSTED);
    assign req_atomic = (udev_req_cmd[3:0] == OP_ATOMIC) && (udev_req_cmd[15:8] <= AMO_SWAP);
`ifdef UMI_RMW_ERRRESP_EN
    assign req_err    = udev_req_cmd[0] && !(req_read || req_write || req_posted || req_atomic);
`else
    assign req_err    = 1'b0;
`endif
    assign accept     = udev_req_valid && (state == S_IDLE);

    assign cap_read   = (cmd_q[3:0] == OP_READ);
    assign cap_posted = (cmd_q[3:0] == OP_POSTED);

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (udev_req_valid) begin
                    if (req_read || req_atomic) begin
                        state_next = S_RD;
                    end else if (req_write || req_posted) begin
                        state_next = S_WR;
                    end else if (req_err) begin
                        state_next = S_RESP;
                    end
                end
            end
            S_RD:    state_next = cap_read ? S_RESP : S_RMW;
            S_RMW:   state_next = S_RESP;
            S_WR:    state_next = cap_posted ? S_IDLE : S_RESP;
            S_RESP:  state_next = udev_resp_ready ? S_IDLE : S_RESP;
            default: state_next = S_IDLE;
        endcase
    end

    // Atomic operation on the freshly read memory value
    always_comb begin
        rmw_result = loc_rddata;
        case (cmd_q[15:8])
            AMO_ADD:  rmw_result = loc_rddata + data_q;
            AMO_AND:  rmw_result = loc_rddata & data_q;
            AMO_OR:   rmw_result = loc_rddata | data_q;
            AMO_XOR:  rmw_result = loc_rddata ^ data_q;
            AMO_MAX:  rmw_result = ($signed(loc_rddata) > $signed(data_q)) ? loc_rddata : data_q;
            AMO_MIN:  rmw_result = ($signed(loc_rddata) < $signed(data_q)) ? loc_rddata : data_q;
            AMO_MAXU: rmw_result = (loc_rddata > data_q) ? loc_rddata : data_q;
            AMO_MINU: rmw_result = (loc_rddata < data_q) ? loc_rddata : data_q;
            AMO_SWAP: rmw_result = data_q;
            default:  rmw_result = loc_rddata;
        endcase
    end

    // Response command: opcode rewritten, upper fields copied from the request
    always_comb begin
        resp_cmd_c = cmd_q;
        if (err_q) begin
            resp_cmd_c[15:8] = 8'hFF;
            resp_cmd_c[3:0]  = OP_RESP_WRITE;
        end else if (cmd_q[3:0] == OP_WRITE) begin
            resp_cmd_c[3:0]  = OP_RESP_WRITE;
        end else begin
            resp_cmd_c[3:0]  = OP_RESP_READ;
        end
    end

    // Output decode from the current state
    always_comb begin
        udev_req_ready    = 1'b0;
        udev_resp_valid   = 1'b0;
        udev_resp_cmd     = '0;
        udev_resp_dstaddr = '0;
        udev_resp_data    = '0;
        loc_read          = 1'b0;
        loc_write         = 1'b0;
        loc_addr          = '0;
        loc_wrdata        = '0;
        case (state)
            S_IDLE: udev_req_ready = nreset;
            S_RD: begin
                loc_read = 1'b1;
                loc_addr = dst_q;
            end
            S_RMW: begin
                loc_write  = 1'b1;
                loc_addr   = dst_q;
                loc_wrdata = rmw_result;
            end
            S_WR: begin
                loc_write  = 1'b1;
                loc_addr   = dst_q;
                loc_wrdata = data_q;
            end
            S_RESP: begin
                udev_resp_valid   = 1'b1;
                udev_resp_cmd     = resp_cmd_c;
                udev_resp_dstaddr = src_q;
                udev_resp_data    = rd_fresh_q ? loc_rddata : old_q;
            end
            default: ;
        endcase
    end

    // Request capture and response data holding
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cmd_q      <= '0;
            dst_q      <= '0;
            src_q      <= '0;
            data_q     <= '0;
            old_q      <= '0;
            rd_fresh_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd_q      <= udev_req_cmd;
                        dst_q      <= udev_req_dstaddr;
                        src_q      <= udev_req_srcaddr;
                        data_q     <= udev_req_data;
                        old_q      <= '0;
                        rd_fresh_q <= 1'b0;
                        err_q      <= req_err;
                    end
                end
                S_RD:  rd_fresh_q <= cap_read;
                S_RMW: old_q <= loc_rddata;
                S_RESP: begin
                    // Latch read data so it stays stable through a stall
                    if (rd_fresh_q) begin
                        old_q      <= loc_rddata;
                        rd_fresh_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_umi_rmw_endpoint.sv
// Self-checking bench for umi_rmw_endpoint (CW=32, AW=64, DW=32).
// A transaction-level model turns each accepted request into the sequence of
// output cycles it must produce; a compare process checks every cycle.
module tb_umi_rmw_endpoint;

    localparam int unsigned CW = 32;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 32;

    localparam logic [31:0] C_READ   = 32'h0000_0001;
    localparam logic [31:0] C_WRITE  = 32'h0000_0003;
    localparam logic [31:0] C_POSTED = 32'h0000_0005;
    localparam logic [31:0] C_ATOMIC = 32'h0000_0009;

    logic          clk;
    logic          nreset;
    logic          udev_req_valid;
    logic [CW-1:0] udev_req_cmd;
    logic [AW-1:0] udev_req_dstaddr;
    logic [AW-1:0] udev_req_srcaddr;
    logic [DW-1:0] udev_req_data;
    logic          udev_req_ready;
    logic          udev_resp_valid;
    logic [CW-1:0] udev_resp_cmd;
    logic [AW-1:0] udev_resp_dstaddr;
    logic [DW-1:0] udev_resp_data;
    logic          udev_resp_ready;
    logic          loc_read;
    logic          loc_write;
    logic [AW-1:0] loc_addr;
    logic [DW-1:0] loc_wrdata;
    logic [DW-1:0] loc_rddata;

    int n_checks = 0;
    int n_err    = 0;

    umi_rmw_endpoint #(.CW(CW), .AW(AW), .DW(DW)) dut (
        .clk               (clk),
        .nreset            (nreset),
        .udev_req_valid    (udev_req_valid),
        .udev_req_cmd      (udev_req_cmd),
        .udev_req_dstaddr  (udev_req_dstaddr),
        .udev_req_srcaddr  (udev_req_srcaddr),
        .udev_req_data     (udev_req_data),
        .udev_req_ready    (udev_req_ready),
        .udev_resp_valid   (udev_resp_valid),
        .udev_resp_cmd     (udev_resp_cmd),
        .udev_resp_dstaddr (udev_resp_dstaddr),
        .udev_resp_data    (udev_resp_data),
        .udev_resp_ready   (udev_resp_ready),
        .loc_read          (loc_read),
        .loc_write         (loc_write),
        .loc_addr          (loc_addr),
        .loc_wrdata        (loc_wrdata),
        .loc_rddata        (loc_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Local memory attached to the DUT; read data is only meaningful for one cycle
    logic [31:0] mem [logic [63:0]];

    function automatic logic [31:0] mem_rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(posedge clk) begin
        if (loc_write) mem[loc_addr] = loc_wrdata;
        if (loc_read) loc_rddata <= mem_rd(loc_addr);
        else          loc_rddata <= $urandom;
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic        rv;
        logic [63:0] addr;
        logic [31:0] wdata;
        logic [31:0] rcmd;
        logic [63:0] rdst;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl_mem [logic [63:0]];

    function automatic exp_t blank();
        exp_t e;
        e.rd = 0; e.wr = 0; e.rv = 0; e.addr = '0; e.wdata = '0;
        e.rcmd = '0; e.rdst = '0; e.rdata = '0;
        return e;
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [63:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] amo(input logic [7:0] sub, input logic [31:0] m, input logic [31:0] op);
        int signed sm, so;
        sm = m; so = op;
        case (sub)
            8'h00:   return m + op;
            8'h01:   return m & op;
            8'h02:   return m | op;
            8'h03:   return m ^ op;
            8'h04:   return (sm > so) ? m : op;
            8'h05:   return (sm < so) ? m : op;
            8'h06:   return (m > op) ? m : op;
            8'h07:   return (m < op) ? m : op;
            default: return op;
        endcase
    endfunction

    task automatic model_accept(input logic [31:0] c, input logic [63:0] d,
                                input logic [63:0] s, input logic [31:0] w);
        exp_t a, r;
        logic [31:0] old;
        a = blank(); r = blank();
        r.rv = 1; r.rdst = s; r.rcmd = {c[31:4], 4'h2};
        old = mdl_rd(d);
        if (c[3:0] == 4'h1) begin
            a.rd = 1; a.addr = d; exp_q.push_back(a);
            r.rdata = old; exp_q.push_back(r);
        end else if (c[3:0] == 4'h9 && c[15:8] <= 8'h08) begin
            a.rd = 1; a.addr = d; exp_q.push_back(a);
            a = blank(); a.wr = 1; a.addr = d; a.wdata = amo(c[15:8], old, w); exp_q.push_back(a);
            r.rdata = old; exp_q.push_back(r);
        end else if (c[3:0] == 4'h3 || c[3:0] == 4'h5) begin
            a.wr = 1; a.addr = d; a.wdata = w; exp_q.push_back(a);
            if (c[3:0] == 4'h3) begin
                r.rcmd = {c[31:4], 4'h4}; exp_q.push_back(r);
            end
        end
`ifdef UMI_RMW_ERRRESP_EN
        else if (c[0]) begin
            r.rcmd = {c[31:16], 8'hFF, c[7:4], 4'h4}; exp_q.push_back(r);
        end
`endif
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin : cmp
        exp_t e;
        logic rdy;
        if (!nreset) begin
            chk("reset_strobes", {60'd0, udev_req_ready, loc_read, loc_write, udev_resp_valid}, 64'd0);
            chk("reset_loc_addr", loc_addr, 64'd0);
            chk("reset_resp_cmd", {32'd0, udev_resp_cmd}, 64'd0);
            chk("reset_resp_data", {32'd0, udev_resp_data}, 64'd0);
            exp_q.delete();
        end else begin
            if (exp_q.size() == 0) begin e = blank(); rdy = 1; end
            else begin e = exp_q[0]; rdy = 0; end
            chk("strobes", {60'd0, udev_req_ready, loc_read, loc_write, udev_resp_valid},
                {60'd0, rdy, e.rd, e.wr, e.rv});
            chk("loc_addr", loc_addr, e.addr);
            chk("loc_wrdata", {32'd0, loc_wrdata}, {32'd0, e.wdata});
            chk("resp_cmd", {32'd0, udev_resp_cmd}, {32'd0, e.rcmd});
            chk("resp_dstaddr", udev_resp_dstaddr, e.rdst);
            chk("resp_data", {32'd0, udev_resp_data}, {32'd0, e.rdata});
            if (exp_q.size() == 0) begin
                if (udev_req_valid)
                    model_accept(udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr, udev_req_data);
            end else if (!e.rv || udev_resp_ready) begin
                if (e.wr) mdl_mem[e.addr] = e.wdata;
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    // Presents a request and waits for acceptance; n = negedges until ready seen
    task automatic issue(input logic [31:0] c, input logic [63:0] d, input logic [63:0] s,
                         input logic [31:0] w, input bit sync, output int n);
        if (sync) begin @(posedge clk); #1; end
        udev_req_cmd = c; udev_req_dstaddr = d; udev_req_srcaddr = s; udev_req_data = w;
        udev_req_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (udev_req_ready) break;
        end
        if (!udev_req_ready) begin
            n_checks++; n_err++;
            $display("FAIL accept_timeout: cmd %h never accepted", c);
            udev_req_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            udev_req_valid = 1'b0;
        end
    endtask

    // Issues a request and returns the first response cycle seen after acceptance
    task automatic do_req(input logic [31:0] c, input logic [63:0] d, input logic [63:0] s,
                          input logic [31:0] w, output int lat, output logic [31:0] rcmd,
                          output logic [63:0] rdst, output logic [31:0] rdata);
        int n;
        issue(c, d, s, w, 1'b1, n);
        lat = 0; rcmd = '0; rdst = '0; rdata = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (udev_resp_valid) begin
                lat = i; rcmd = udev_resp_cmd; rdst = udev_resp_dstaddr; rdata = udev_resp_data;
                break;
            end
        end
        if (lat == 0) begin
            n_checks++; n_err++;
            $display("FAIL resp_timeout: cmd %h produced no response", c);
        end
    endtask

    initial begin
        int lat, n;
        logic [31:0] rcmd, rdata;
        logic [63:0] rdst;

        nreset = 1'b1; udev_req_valid = 1'b0; udev_req_cmd = '0; udev_req_dstaddr = '0;
        udev_req_srcaddr = '0; udev_req_data = '0; udev_resp_ready = 1'b1;
        #2 nreset = 1'b0;
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;

        // WRITE then READ back
        issue(C_WRITE, 64'h10, 64'h80, 32'hDEADBEEF, 1'b1, n);
        @(negedge clk);
        chk("wr_t1_loc_write", {63'd0, loc_write}, 64'd1);
        chk("wr_t1_wrdata", {32'd0, loc_wrdata}, 64'hDEADBEEF);
        @(negedge clk);
        chk("wr_t2_resp_valid", {63'd0, udev_resp_valid}, 64'd1);
        chk("wr_resp_op", {60'd0, udev_resp_cmd[3:0]}, 64'h4);
        chk("wr_resp_dst", udev_resp_dstaddr, 64'h80);

        issue(C_READ, 64'h10, 64'h90, 32'h0, 1'b1, n);
        @(negedge clk);
        chk("rd_t1_loc_read", {63'd0, loc_read}, 64'd1);
        @(negedge clk);
        chk("rd_t2_resp_valid", {63'd0, udev_resp_valid}, 64'd1);
        chk("rd_resp_data", {32'd0, udev_resp_data}, 64'hDEADBEEF);
        chk("rd_resp_op", {60'd0, udev_resp_cmd[3:0]}, 64'h2);

        // ATOMIC ADD wraps
        do_req(C_WRITE, 64'h20, 64'h80, 32'hFFFFFFFF, lat, rcmd, rdst, rdata);
        do_req(C_ATOMIC, 64'h20, 64'hA0, 32'h2, lat, rcmd, rdst, rdata);
        chk("add_latency", 64'(lat), 64'd3);
        chk("add_old", {32'd0, rdata}, 64'hFFFFFFFF);
        do_req(C_READ, 64'h20, 64'hA0, 32'h0, lat, rcmd, rdst, rdata);
        chk("add_wrapped", {32'd0, rdata}, 64'h1);

        // MAX (signed) vs MAXU (unsigned)
        do_req(C_WRITE, 64'h30, 64'h80, 32'h80000000, lat, rcmd, rdst, rdata);
        do_req(C_WRITE, 64'h38, 64'h80, 32'h80000000, lat, rcmd, rdst, rdata);
        do_req(32'h0000_0409, 64'h30, 64'hB0, 32'h1, lat, rcmd, rdst, rdata);
        chk("max_old", {32'd0, rdata}, 64'h80000000);
        do_req(32'h0000_0609, 64'h38, 64'hB8, 32'h1, lat, rcmd, rdst, rdata);
        chk("maxu_old", {32'd0, rdata}, 64'h80000000);
        chk("max_mem", {32'd0, mem[64'h30]}, 64'h1);
        chk("maxu_mem", {32'd0, mem[64'h38]}, 64'h80000000);

        // All subtypes, negative memory value vs positive operand
        for (int sub = 0; sub <= 8; sub++) begin
            do_req(C_WRITE, 64'h100 + 64'(sub * 8), 64'h80, 32'hF000_0010, lat, rcmd, rdst, rdata);
            do_req({16'h0, 8'(sub), 8'h09}, 64'h100 + 64'(sub * 8), 64'hC0, 32'h0000_0100,
                   lat, rcmd, rdst, rdata);
            do_req(C_READ, 64'h100 + 64'(sub * 8), 64'hC8, 32'h0, lat, rcmd, rdst, rdata);
        end
        chk("minu_mem", {32'd0, mem[64'h138]}, 64'h0000_0100);
        chk("min_mem", {32'd0, mem[64'h128]}, 64'hF000_0010);

        // POSTED, then READ held valid; response stalled for 5 cycles
        issue(C_POSTED, 64'h50, 64'h80, 32'h12345678, 1'b1, n);
        udev_resp_ready = 1'b0;
        issue(C_READ, 64'h50, 64'hD0, 32'h0, 1'b0, n);
        chk("b2b_accept_cycle", 64'(n), 64'd2);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_resp_valid", {63'd0, udev_resp_valid}, 64'd1);
            chk("stall_req_ready", {63'd0, udev_req_ready}, 64'd0);
            chk("stall_resp_data", {32'd0, udev_resp_data}, 64'h12345678);
        end
        @(posedge clk); #1 udev_resp_ready = 1'b1;

        // Reset during RMW: no write lands, response discarded
        do_req(C_WRITE, 64'h60, 64'h80, 32'h11, lat, rcmd, rdst, rdata);
        issue(C_ATOMIC, 64'h60, 64'hE0, 32'h5, 1'b1, n);
        @(posedge clk); #1 nreset = 1'b0;
        @(negedge clk);
        chk("rst_rmw_loc_write", {63'd0, loc_write}, 64'd0);
        chk("rst_rmw_resp_valid", {63'd0, udev_resp_valid}, 64'd0);
        @(posedge clk); #1 nreset = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", {63'd0, udev_req_ready}, 64'd1);
        do_req(C_READ, 64'h60, 64'hE8, 32'h0, lat, rcmd, rdst, rdata);
        chk("rst_mem_unchanged", {32'd0, rdata}, 64'h11);

        // Unsupported atomic subtype
        issue(32'h0000_2009, 64'h60, 64'hF0, 32'h7, 1'b1, n);
        @(negedge clk);
`ifdef UMI_RMW_ERRRESP_EN
        chk("bad_amo_resp_valid", {63'd0, udev_resp_valid}, 64'd1);
        chk("bad_amo_resp_cmd", {32'd0, udev_resp_cmd}, 64'h0000_FF04);
`else
        chk("bad_amo_resp_valid", {63'd0, udev_resp_valid}, 64'd0);
        chk("bad_amo_ready", {63'd0, udev_req_ready}, 64'd1);
`endif

        // Other dropped / unsupported commands, checked by the model
        issue(32'h0000_0000, 64'h60, 64'hF0, 32'h7, 1'b1, n);
        issue(32'h0000_0002, 64'h60, 64'hF0, 32'h7, 1'b1, n);
        issue(32'h0000_000B, 64'h60, 64'hF0, 32'h7, 1'b1, n);
        do_req(C_READ, 64'h60, 64'hF8, 32'h0, lat, rcmd, rdst, rdata);
        chk("dropped_no_write", {32'd0, rdata}, 64'h11);

        repeat (4) @(posedge clk);
        #1;
        chk("model_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
